// File: rtl/vga_rom_arbiter.sv
// Shared single-port ROM arbiter: display fetches have absolute priority,
// two background requesters share the leftover slots round-robin.
module vga_rom_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int STARVE_LIM = 800
) (
  input  logic              i_clk_25M,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_a_req,
  input  logic [ADDR_W-1:0] i_a_addr,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_a_starve,
  output logic              o_b_starve
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_A    = 2'd2;
  localparam logic [1:0] TAG_B    = 2'd3;

  logic [1:0]        tag_r;
  logic              rr_last_r;
  logic              rst_hold_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [CNT_W-1:0]  a_cnt_r;
  logic [CNT_W-1:0]  b_cnt_r;

  logic              rom_en_s;
  logic              a_gnt_s;
  logic              b_gnt_s;
  logic [1:0]        tag_nxt_s;
  logic [ADDR_W-1:0] rom_addr_s;

  // grant selection; grants are held off during reset and the cycle after it
  always_comb begin
    rom_en_s   = 1'b0;
    a_gnt_s    = 1'b0;
    b_gnt_s    = 1'b0;
    tag_nxt_s  = TAG_NONE;
    rom_addr_s = addr_hold_r;
    if (i_rst || rst_hold_r) begin
      rom_addr_s = '0;
    end else if (i_disp_req) begin
      rom_en_s   = 1'b1;
      tag_nxt_s  = TAG_DISP;
      rom_addr_s = i_disp_addr;
    end else if (i_a_req && (!i_b_req || rr_last_r)) begin
      rom_en_s   = 1'b1;
      a_gnt_s    = 1'b1;
      tag_nxt_s  = TAG_A;
      rom_addr_s = i_a_addr;
    end else if (i_b_req) begin
      rom_en_s   = 1'b1;
      b_gnt_s    = 1'b1;
      tag_nxt_s  = TAG_B;
      rom_addr_s = i_b_addr;
    end else begin
      rom_en_s   = 1'b0;
    end
  end

  // response tag, round-robin pointer, address hold and wait counters
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      tag_r       <= TAG_NONE;
      rr_last_r   <= 1'b1;
      rst_hold_r  <= 1'b1;
      addr_hold_r <= '0;
      a_cnt_r     <= '0;
      b_cnt_r     <= '0;
    end else begin
      tag_r      <= tag_nxt_s;
      rst_hold_r <= 1'b0;
      if (a_gnt_s || b_gnt_s) begin
        rr_last_r <= b_gnt_s;
      end
      if (rom_en_s) begin
        addr_hold_r <= rom_addr_s;
      end
      if (!i_a_req || a_gnt_s) begin
        a_cnt_r <= '0;
      end else if (a_cnt_r != LIM_C) begin
        a_cnt_r <= a_cnt_r + CNT_W'(1);
      end
      if (!i_b_req || b_gnt_s) begin
        b_cnt_r <= '0;
      end else if (b_cnt_r != LIM_C) begin
        b_cnt_r <= b_cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_rom_en   = rom_en_s;
  assign o_rom_addr = rom_addr_s;
  assign o_a_gnt    = a_gnt_s;
  assign o_b_gnt    = b_gnt_s;

  // the i_rst mask kills a response whose read was in flight when reset hit
  assign o_disp_valid = (tag_r == TAG_DISP) && !i_rst;
  assign o_a_rvalid   = (tag_r == TAG_A) && !i_rst;
  assign o_b_rvalid   = (tag_r == TAG_B) && !i_rst;

  assign o_disp_data = i_rom_data;
  assign o_a_rdata   = i_rom_data;
  assign o_b_rdata   = i_rom_data;

  assign o_a_starve = (a_cnt_r == LIM_C) && !i_rst;
  assign o_b_starve = (b_cnt_r == LIM_C) && !i_rst;

endmodule
